// File: rtl/bp_me_pkg.sv
// bp_me_pkg: processor config, BedRock mem message types and cache DMA packet for the DMA-to-CCE bridge.
package bp_me_pkg;
  typedef enum logic [1:0] {e_idle, e_send_rd, e_send_wr} bp_me_dma_state_e;
  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;
  typedef struct packed {
    int paddr_width;
    int cce_block_width;
    int dword_width;
    int lce_id_width;
    int lce_assoc;
  } bp_proc_param_s;
  localparam bp_proc_param_s bp_default_cfg_gp = '{paddr_width: 40, cce_block_width: 512, dword_width: 64, lce_id_width: 4, lce_assoc: 8};
  localparam int paddr_width_gp = bp_default_cfg_gp.paddr_width;
  localparam int lce_id_width_gp = bp_default_cfg_gp.lce_id_width;
  localparam int way_id_width_gp = $clog2(bp_default_cfg_gp.lce_assoc);
  typedef enum logic [3:0] {
    e_bedrock_mem_rd = 4'd0,
    e_bedrock_mem_wr = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre = 4'd4,
    e_bedrock_mem_amo = 4'd5
  } bp_bedrock_mem_type_e;
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1, e_bedrock_msg_size_2, e_bedrock_msg_size_4, e_bedrock_msg_size_8,
    e_bedrock_msg_size_16, e_bedrock_msg_size_32, e_bedrock_msg_size_64, e_bedrock_msg_size_128
  } bp_bedrock_msg_size_e;
  typedef struct packed {
    logic [lce_id_width_gp-1:0] lce_id;
    logic [way_id_width_gp-1:0] way_id;
  } bp_bedrock_mem_payload_s;
  typedef struct packed {
    bp_bedrock_mem_payload_s payload;
    bp_bedrock_msg_size_e size;
    logic [paddr_width_gp-1:0] addr;
    bp_bedrock_mem_type_e msg_type;
  } bp_bedrock_cce_mem_msg_header_s;
  typedef struct packed {
    logic write_not_read;
    logic [paddr_width_gp-1:0] addr;
  } bsg_cache_dma_pkt_s;
  localparam int bp_bedrock_cce_mem_msg_header_width_gp = $bits(bp_bedrock_cce_mem_msg_header_s);
  localparam int bsg_cache_dma_pkt_width_gp = $bits(bsg_cache_dma_pkt_s);
  function automatic bp_proc_param_s bp_cfg_f(bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? bp_default_cfg_gp : '0;
  endfunction
  function automatic int safe_clog2_f(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  // Message size encodes log2 of the byte count.
  function automatic bp_bedrock_msg_size_e block_size_f(int block_width);
    return bp_bedrock_msg_size_e'($clog2(block_width / 8));
  endfunction
endpackage

// File: rtl/bp_me_cache_dma_resp_demux.sv
// bp_me_cache_dma_resp_demux: counts read response beats and steers them to the fill port; write acks are sunk in one beat.
module bp_me_cache_dma_resp_demux
  import bp_me_pkg::*;
 #(parameter int data_width_p = 64
  , parameter int stream_words_p = 8
  )
  (input logic clk_i
  , input logic reset_i
  , input bp_bedrock_mem_type_e msg_type_i
  , input logic v_i
  , input logic [data_width_p-1:0] data_i
  , output logic yumi_o
  , output logic [data_width_p-1:0] fill_data_o
  , output logic fill_v_o
  , input logic fill_ready_i
  , output logic last_o
  );
  localparam int cnt_width_lp = safe_clog2_f(stream_words_p);
  logic [cnt_width_lp-1:0] rd_cnt_r;
  logic is_rd, rd_last;
  assign is_rd = msg_type_i inside {e_bedrock_mem_rd, e_bedrock_mem_uc_rd};
  assign rd_last = rd_cnt_r == cnt_width_lp'(stream_words_p - 1);
  assign fill_v_o = v_i & is_rd;
  assign fill_data_o = data_i;
  assign yumi_o = is_rd ? fill_v_o & fill_ready_i : v_i;
  assign last_o = yumi_o & (~is_rd | rd_last);
  always_ff @(posedge clk_i)
    if (reset_i)
      rd_cnt_r <= '0;
    else if (yumi_o & is_rd)
      rd_cnt_r <= rd_last ? '0 : rd_cnt_r + 1'b1;
endmodule

// File: rtl/bp_me_cache_dma_to_cce.sv
// bp_me_cache_dma_to_cce: bsg_cache DMA port to BedRock mem command/response streams.
// Define BP_ME_DMA_FILL_FIFO_EN to buffer fill beats in a 2-entry FIFO.
module bp_me_cache_dma_to_cce
  import bp_me_pkg::*;
 #(parameter bp_params_e bp_params_p = e_bp_default_cfg
  , parameter int dma_data_width_p = bp_default_cfg_gp.dword_width
  , parameter int outstanding_max_p = 4
  )
  (input logic clk_i
  , input logic reset_i
  , input logic [bsg_cache_dma_pkt_width_gp-1:0] dma_pkt_i
  , input logic dma_pkt_v_i
  , output logic dma_pkt_yumi_o
  , output logic [dma_data_width_p-1:0] dma_data_o
  , output logic dma_data_v_o
  , input logic dma_data_ready_i
  , input logic [dma_data_width_p-1:0] dma_data_i
  , input logic dma_data_v_i
  , output logic dma_data_yumi_o
  , output logic [bp_bedrock_cce_mem_msg_header_width_gp-1:0] mem_cmd_header_o
  , output logic [dma_data_width_p-1:0] mem_cmd_data_o
  , output logic mem_cmd_v_o
  , input logic mem_cmd_ready_i
  , output logic mem_cmd_lock_o
  , input logic [bp_bedrock_cce_mem_msg_header_width_gp-1:0] mem_resp_header_i
  , input logic [dma_data_width_p-1:0] mem_resp_data_i
  , input logic mem_resp_v_i
  , output logic mem_resp_yumi_o
  , input logic mem_resp_lock_i
  );
  localparam bp_proc_param_s proc_param_lp = bp_cfg_f(bp_params_p);
  localparam int cce_block_width_p = proc_param_lp.cce_block_width;
  localparam int stream_words_lp = cce_block_width_p / dma_data_width_p;
  localparam int cnt_width_lp = safe_clog2_f(stream_words_lp);
  localparam int ow_lp = $clog2(outstanding_max_p + 1);
  bsg_cache_dma_pkt_s pkt;
  bp_bedrock_cce_mem_msg_header_s hdr_r, resp_hdr;
  bp_me_dma_state_e state_r, state_n;
  logic [cnt_width_lp-1:0] wr_cnt_r;
  logic [ow_lp-1:0] outstanding_r;
  logic wr_last, resp_done, dec;
  logic [dma_data_width_p-1:0] fill_data;
  logic fill_v, fill_ready;
  logic unused;
  assign pkt = dma_pkt_i;
  assign resp_hdr = mem_resp_header_i;
  assign mem_cmd_header_o = hdr_r;
  assign wr_last = wr_cnt_r == cnt_width_lp'(stream_words_lp - 1);
  assign dec = resp_done & (outstanding_r != '0);
  assign unused = ^{mem_resp_lock_i, resp_hdr.payload, resp_hdr.size, resp_hdr.addr};
  always_comb begin
    state_n = state_r;
    dma_pkt_yumi_o = 1'b0;
    dma_data_yumi_o = 1'b0;
    mem_cmd_v_o = 1'b0;
    mem_cmd_data_o = '0;
    mem_cmd_lock_o = 1'b0;
    case (state_r)
      e_idle: begin
        dma_pkt_yumi_o = dma_pkt_v_i & (outstanding_r != ow_lp'(outstanding_max_p));
        if (dma_pkt_yumi_o)
          state_n = pkt.write_not_read ? e_send_wr : e_send_rd;
      end
      e_send_rd: begin
        mem_cmd_v_o = 1'b1;
        state_n = mem_cmd_ready_i ? e_idle : e_send_rd;
      end
      e_send_wr: begin
        mem_cmd_v_o = dma_data_v_i;
        mem_cmd_data_o = dma_data_i;
        dma_data_yumi_o = dma_data_v_i & mem_cmd_ready_i;
        mem_cmd_lock_o = ~wr_last;
        state_n = (dma_data_yumi_o & wr_last) ? e_idle : e_send_wr;
      end
      default: state_n = e_idle;
    endcase
  end
  // Header is registered so the command starts the cycle after the packet is taken.
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_r <= e_idle;
      hdr_r <= '0;
      wr_cnt_r <= '0;
      outstanding_r <= '0;
    end else begin
      state_r <= state_n;
      if (dma_pkt_yumi_o)
        hdr_r <= '{payload: '0
                 , size: block_size_f(cce_block_width_p)
                 , addr: pkt.addr & ~paddr_width_gp'(cce_block_width_p / 8 - 1)
                 , msg_type: pkt.write_not_read ? e_bedrock_mem_wr : e_bedrock_mem_rd};
      if (dma_data_yumi_o)
        wr_cnt_r <= wr_last ? '0 : wr_cnt_r + 1'b1;
      outstanding_r <= outstanding_r + ow_lp'(dma_pkt_yumi_o) - ow_lp'(dec);
    end
  bp_me_cache_dma_resp_demux #(.data_width_p(dma_data_width_p), .stream_words_p(stream_words_lp)) demux
    (.clk_i(clk_i)
    , .reset_i(reset_i)
    , .msg_type_i(resp_hdr.msg_type)
    , .v_i(mem_resp_v_i)
    , .data_i(mem_resp_data_i)
    , .yumi_o(mem_resp_yumi_o)
    , .fill_data_o(fill_data)
    , .fill_v_o(fill_v)
    , .fill_ready_i(fill_ready)
    , .last_o(resp_done)
    );
`ifdef BP_ME_DMA_FILL_FIFO_EN
  logic [dma_data_width_p-1:0] fifo_mem_r [2];
  logic wptr_r, rptr_r, enq, deq;
  logic [1:0] fifo_cnt_r;
  assign fill_ready = fifo_cnt_r != 2'd2;
  assign enq = fill_v & fill_ready;
  assign deq = dma_data_v_o & dma_data_ready_i;
  assign dma_data_v_o = fifo_cnt_r != 2'd0;
  assign dma_data_o = fifo_mem_r[rptr_r];
  always_ff @(posedge clk_i)
    if (reset_i) begin
      wptr_r <= 1'b0;
      rptr_r <= 1'b0;
      fifo_cnt_r <= 2'd0;
    end else begin
      if (enq) begin
        fifo_mem_r[wptr_r] <= fill_data;
        wptr_r <= ~wptr_r;
      end
      if (deq)
        rptr_r <= ~rptr_r;
      fifo_cnt_r <= fifo_cnt_r + 2'(enq) - 2'(deq);
    end
`else
  assign fill_ready = dma_data_ready_i;
  assign dma_data_o = fill_data;
  assign dma_data_v_o = fill_v;
`endif
  resp_pending_a: assert property (@(posedge clk_i) disable iff (reset_i) mem_resp_v_i |-> outstanding_r != '0);
  resp_type_a: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_resp_v_i |-> resp_hdr.msg_type inside {e_bedrock_mem_rd, e_bedrock_mem_wr, e_bedrock_mem_uc_rd, e_bedrock_mem_uc_wr});
endmodule
